// File: rtl/norm_column_sequencer.sv
// Sequences one column through the norm unit: buffer + stream, wait for 1/||col||, then emit scaled q.
// Optional: define NCS_TIMEOUT_EN to abandon a column whose reciprocal does not arrive in TIMEOUT_CYC cycles.
module norm_column_sequencer #(
  parameter int WIDTH       = 16,
  parameter int Q           = 8,
  parameter int COL_LEN     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             col_v_i,
  input  logic [WIDTH-1:0] col_data_i,
  output logic             col_ready_o,
  output logic             norm_v_o,
  output logic [WIDTH-1:0] norm_data_o,
  input  logic             norm_ready_i,
  output logic             norm_done_acc_o,
  input  logic             recip_v_i,
  input  logic [WIDTH-1:0] recip_i,
  input  logic             recip_ovf_i,
  output logic             q_v_o,
  output logic [WIDTH-1:0] q_data_o,
  input  logic             q_yumi_i,
  output logic             busy_o,
  output logic             err_o,
  output logic [2:0]       dbg_state_o
);

  // Handshakes: an element moves on a cycle where col_v_i & col_ready_o (and thus norm_v_o) are high;
  // a q element moves on a cycle where q_v_o & q_yumi_i are high, and q_v_o/q_data_o hold until then.

  localparam int IDX_W = (COL_LEN > 1) ? $clog2(COL_LEN) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COL_LEN - 1);
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_DONE_ACC   = 3'd2,
    S_WAIT_RECIP = 3'd3,
    S_SCALE      = 3'd4
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [WIDTH-1:0]        recip_reg;
  logic                    ovf_reg;
  logic signed [WIDTH-1:0] buf_mem [COL_LEN];
  logic                    col_accept;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    shifted;
  logic                    fits;
  logic [WIDTH-1:0]        sat_val;
  logic                    unused_recip_msb;

  assign unused_recip_msb = recip_i[WIDTH-1];

`ifdef NCS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign col_accept      = (state == S_LOAD) && col_v_i && norm_ready_i;
  assign col_ready_o     = (state == S_LOAD) && norm_ready_i;
  assign norm_v_o        = col_accept;
  assign norm_data_o     = (state == S_LOAD) ? col_data_i : '0;
  assign norm_done_acc_o = (state == S_DONE_ACC);
  assign q_v_o           = (state == S_SCALE);
  assign busy_o          = (state != S_IDLE);
  assign dbg_state_o     = state;

  // Full-width signed product; the reciprocal's top bit is forced to 0 so it acts as a magnitude.
  always_comb begin
    prod    = PW'($signed(buf_mem[idx])) * PW'($signed(recip_reg));
    shifted = prod >>> Q;
    fits    = (shifted[PW-1:WIDTH-1] == {(PW-WIDTH+1){shifted[PW-1]}});
    if (fits) begin
      sat_val = shifted[WIDTH-1:0];
    end else if (shifted[PW-1]) begin
      sat_val = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign q_data_o = ((state == S_SCALE) && !ovf_reg) ? sat_val : '0;

  always_ff @(posedge clk_i) begin
    if (col_accept) begin
      buf_mem[idx] <= col_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= S_IDLE;
      idx       <= '0;
      recip_reg <= '0;
      ovf_reg   <= 1'b0;
      err_o     <= 1'b0;
`ifdef NCS_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          idx   <= '0;
          state <= S_LOAD;
        end
        S_LOAD: begin
          if (col_accept) begin
            // The error of the previous column stays visible until the new column really starts.
            if (idx == '0) begin
              err_o <= 1'b0;
            end
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= S_DONE_ACC;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_DONE_ACC: begin
          state <= S_WAIT_RECIP;
`ifdef NCS_TIMEOUT_EN
          wait_cnt <= CNT_W'(1);
`endif
        end
        S_WAIT_RECIP: begin
          if (recip_v_i) begin
            recip_reg <= {1'b0, recip_i[WIDTH-2:0]};
            ovf_reg   <= recip_ovf_i;
            state     <= S_SCALE;
`ifdef NCS_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
`ifdef NCS_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            err_o    <= 1'b1;
            wait_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_SCALE: begin
          if (ovf_reg) begin
            err_o <= 1'b1;
          end
          if (q_yumi_i) begin
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= S_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_column_sequencer.sv
// Directed bench for norm_column_sequencer: arithmetic reference model, per-cycle compare process, literal pins.
// Build with NCS_TIMEOUT_EN defined to also exercise the reciprocal timeout.
module tb_norm_column_sequencer;

  localparam int W       = 16;
  localparam int COL_LEN = 4;
  localparam int TMO     = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         col_v_i = 1'b0;
  logic [W-1:0] col_data_i = '0;
  logic         col_ready_o;
  logic         norm_v_o;
  logic [W-1:0] norm_data_o;
  logic         norm_ready_i = 1'b1;
  logic         norm_done_acc_o;
  logic         recip_v_i = 1'b0;
  logic [W-1:0] recip_i = '0;
  logic         recip_ovf_i = 1'b0;
  logic         q_v_o;
  logic [W-1:0] q_data_o;
  logic         q_yumi_i = 1'b0;
  logic         busy_o;
  logic         err_o;
  logic [2:0]   dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] cur_col [COL_LEN];
  int           done_cnt = 0;
  int           acc_cnt  = 0;

  norm_column_sequencer #(.WIDTH(W), .Q(8), .COL_LEN(COL_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .reset_i(rst_n),
    .col_v_i(col_v_i), .col_data_i(col_data_i), .col_ready_o(col_ready_o),
    .norm_v_o(norm_v_o), .norm_data_o(norm_data_o), .norm_ready_i(norm_ready_i),
    .norm_done_acc_o(norm_done_acc_o),
    .recip_v_i(recip_v_i), .recip_i(recip_i), .recip_ovf_i(recip_ovf_i),
    .q_v_o(q_v_o), .q_data_o(q_data_o), .q_yumi_i(q_yumi_i),
    .busy_o(busy_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
  endtask

  // q = sat16(elem * |recip| / 256), or 0 when the divider overflowed.
  function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] r, input bit ovf);
    longint p;
    if (ovf) return '0;
    p = longint'($signed(a)) * longint'(r & 16'h7FFF);
    p = p >>> 8;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return p[W-1:0];
  endfunction

  // ---------------- compare process ----------------
  logic         prev_v = 1'b0, prev_yumi = 1'b0, prev_done = 1'b0;
  logic [W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0; prev_yumi = 1'b0; prev_done = 1'b0;
    end else begin
      chk("norm_v_vs_handshake", norm_v_o, col_v_i & col_ready_o);
      if (col_ready_o) chk("ready_needs_norm_ready", norm_ready_i, 1'b1);
      if (norm_v_o) chk("norm_data_pass", norm_data_o, col_data_i);
      if (col_v_i && col_ready_o) acc_cnt++;
      if (norm_done_acc_o) begin
        done_cnt++;
        chk("done_acc_single_cycle", prev_done, 1'b0);
      end
      if (prev_v && !prev_yumi) begin
        chk("q_v_hold", q_v_o, 1'b1);
        chk("q_data_hold", q_data_o, prev_data);
      end
      if (q_v_o) chk("q_v_expected", exp_q.size() != 0, 1'b1);
      if (q_v_o && q_yumi_i && exp_q.size() != 0) begin
        chk("q_data", q_data_o, exp_q.pop_front());
        got_q.push_back(q_data_o);
      end
      prev_v = q_v_o; prev_yumi = q_yumi_i; prev_data = q_data_o; prev_done = norm_done_acc_o;
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic send_column(input bit toggle_ready);
    bit taken;
    int guard;
    for (int i = 0; i < COL_LEN; i++) begin
      taken = 1'b0;
      guard = 0;
      col_v_i    = 1'b1;
      col_data_i = cur_col[i];
      while (!taken) begin
        norm_ready_i = toggle_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        @(negedge clk);
        taken = col_ready_o;
        @(posedge clk); #1;
        guard++;
        if (!taken && guard > 60) begin
          chk("accept_timeout", 32'(i), 32'(COL_LEN));
          col_v_i = 1'b0; norm_ready_i = 1'b1;
          return;
        end
      end
    end
    col_v_i = 1'b0;
    norm_ready_i = 1'b1;
  endtask

  task automatic wait_done_acc(output bit seen);
    seen = 1'b0;
    for (int g = 0; g < 40 && !seen; g++) begin
      @(negedge clk);
      seen = norm_done_acc_o;
    end
    if (!seen) chk("done_acc_timeout", 0, 1);
  endtask

  task automatic give_recip(input logic [W-1:0] r, input bit ovf, input int delay);
    bit seen;
    wait_done_acc(seen);
    @(posedge clk); #1;
    repeat (delay) begin
      @(negedge clk);
      chk("busy_while_waiting", busy_o, 1'b1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < COL_LEN; i++) exp_q.push_back(model_q(cur_col[i], r, ovf));
    recip_v_i = 1'b1; recip_i = r; recip_ovf_i = ovf;
    @(posedge clk); #1;
    recip_v_i = 1'b0; recip_ovf_i = 1'b0; recip_i = 16'($urandom_range(0, 65535));
    @(negedge clk);
    chk("q_latency", q_v_o, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int stall_at, input int stall_len, output int cycles);
    int taken;
    taken = 0;
    cycles = 0;
    while (taken < COL_LEN && cycles < 100) begin
      if (taken == stall_at && stall_len > 0) begin
        q_yumi_i = 1'b0;
        repeat (stall_len) @(posedge clk);
        #1;
        stall_len = 0;
      end
      q_yumi_i = q_v_o;
      if (q_v_o) taken++;
      @(posedge clk); #1;
      cycles++;
    end
    q_yumi_i = 1'b0;
    if (taken < COL_LEN) chk("drain_timeout", 32'(taken), 32'(COL_LEN));
  endtask

  task automatic set_col(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c, input logic [W-1:0] d);
    cur_col[0] = a; cur_col[1] = b; cur_col[2] = c; cur_col[3] = d;
  endtask

  task automatic chk_got(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c, input logic [W-1:0] d);
    logic [W-1:0] lit [COL_LEN];
    lit[0] = a; lit[1] = b; lit[2] = c; lit[3] = d;
    chk({name, "_count"}, 32'(got_q.size()), 32'(COL_LEN));
    for (int i = 0; i < COL_LEN && i < got_q.size(); i++) chk(name, got_q[i], lit[i]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_col_ready"}, col_ready_o, 1'b0);
    chk({tag, "_norm_v"}, norm_v_o, 1'b0);
    chk({tag, "_norm_data"}, norm_data_o, '0);
    chk({tag, "_done_acc"}, norm_done_acc_o, 1'b0);
    chk({tag, "_q_v"}, q_v_o, 1'b0);
    chk({tag, "_q_data"}, q_data_o, '0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_err"}, err_o, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (20000) @(posedge clk);
    chk("watchdog", 0, 1);
    report();
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  d0, a0, cyc;
    bit  seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset in the middle of LOAD after two accepted elements.
    col_v_i = 1'b1; col_data_i = 16'h1111; norm_ready_i = 1'b1;
    seen = 1'b0;
    for (int g = 0; g < 10 && !seen; g++) begin
      @(negedge clk);
      seen = col_ready_o;
      @(posedge clk); #1;
    end
    chk("first_ready", seen, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midload_reset");
    col_v_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // A reciprocal outside WAIT_RECIP must be ignored.
    recip_v_i = 1'b1; recip_i = 16'h7FFF; recip_ovf_i = 1'b1;
    @(posedge clk); #1;
    recip_v_i = 1'b0; recip_ovf_i = 1'b0;

    // Basic column.
    got_q.delete(); d0 = done_cnt; a0 = acc_cnt;
    set_col(16'h0300, 16'h0400, 16'h0000, 16'h0000);
    send_column(1'b0);
    give_recip(16'h0033, 1'b0, 2);
    drain(-1, 0, cyc);
    chk("basic_throughput", 32'(cyc), 32'(COL_LEN));
    chk("basic_done_pulses", 32'(done_cnt - d0), 1);
    chk("basic_accepts", 32'(acc_cnt - a0), 32'(COL_LEN));
    chk_got("basic_q", 16'h0099, 16'h00CC, 16'h0000, 16'h0000);
    chk("basic_err", err_o, 1'b0);

    // Sign handling, saturation both ways, exact negative full scale.
    got_q.delete(); d0 = done_cnt;
    set_col(16'hFD00, 16'h7F00, 16'h8000, 16'hC000);
    send_column(1'b0);
    give_recip(16'h0200, 1'b0, 0);
    drain(-1, 0, cyc);
    chk("sat_done_pulses", 32'(done_cnt - d0), 1);
    chk_got("sat_q", 16'hFA00, 16'h7FFF, 16'h8000, 16'h8000);

    // Backpressure on both sides; reciprocal bit 15 set must be ignored.
    got_q.delete(); a0 = acc_cnt;
    set_col(16'h0123, 16'hFF80, 16'h0A00, 16'h0001);
    send_column(1'b1);
    give_recip(16'h8155, 1'b0, 0);
    drain(1, 3, cyc);
    chk("bp_accepts", 32'(acc_cnt - a0), 32'(COL_LEN));
    chk_got("bp_q", 16'h0183, 16'hFF55, 16'h0D52, 16'h0001);

    // Divider overflow: zeros and a sticky error.
    got_q.delete();
    set_col(16'h0300, 16'h0400, 16'h7F00, 16'h8000);
    send_column(1'b0);
    give_recip(16'h0033, 1'b1, 1);
    drain(-1, 0, cyc);
    chk_got("ovf_q", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("ovf_err_set", err_o, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("ovf_err_sticky", err_o, 1'b1);
    @(posedge clk); #1;

    // Unity reciprocal after a long wait; the error clears on the first accept.
    got_q.delete();
    set_col(16'h0100, 16'hFE00, 16'h0300, 16'h0400);
    send_column(1'b0);
    chk("err_cleared", err_o, 1'b0);
`ifdef NCS_TIMEOUT_EN
    give_recip(16'h0100, 1'b0, 3);
`else
    give_recip(16'h0100, 1'b0, 30);
`endif
    drain(2, 1, cyc);
    chk_got("unity_q", 16'h0100, 16'hFE00, 16'h0300, 16'h0400);

`ifdef NCS_TIMEOUT_EN
    // Withheld reciprocal: column dropped TMO cycles after the DONE_ACC pulse.
    set_col(16'h1000, 16'h2000, 16'h3000, 16'h4000);
    send_column(1'b0);
    wait_done_acc(seen);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_busy_before", busy_o, 1'b1);
    chk("tmo_err_before", err_o, 1'b0);
    @(negedge clk);
    chk("tmo_busy", busy_o, 1'b0);
    chk("tmo_err", err_o, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    got_q.delete();
    set_col(16'h0200, 16'h0100, 16'hFF00, 16'h0080);
    send_column(1'b0);
    chk("tmo_err_cleared", err_o, 1'b0);
    give_recip(16'h0080, 1'b0, 0);
    drain(-1, 0, cyc);
    chk_got("tmo_recover_q", 16'h0100, 16'h0080, 16'hFF80, 16'h0040);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    report();
    $finish;
  end

endmodule
